// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the round-robin arbiter
package arb_pkg;

    localparam int N_REQ              = 16;
    localparam int ID_W               = 4;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  id,
    output logic [N_REQ-1:0] oh
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    enc;

    // Rotating right by ptr puts requester ptr at bit 0, so lowest-bit priority
    // becomes "first at or after ptr".
    assign req_dbl = {req, req} >> ptr;
    assign rot     = req_dbl[N_REQ-1:0];
    assign any     = |req;

    always_comb begin
        enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = ID_W'(i);
            end
        end
    end

    assign id = enc + ptr;
    assign oh = N_REQ'(1) << id;

endmodule

// File: rtl/rr_arbiter_16.sv
// rtl/rr_arbiter_16.sv - 16-way round-robin grant-and-hold arbiter; ARB_TIMEOUT_EN adds a grant watchdog
module rr_arbiter_16
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)
`endif
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_release,
    output logic             grant_valid,
    output logic [N_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]  grant_id,
    output logic             timeout
);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             valid_d;
    logic [N_REQ-1:0] oh_d;
    logic [ID_W-1:0]  id_d;

    logic             pick_any;
    logic [ID_W-1:0]  pick_id;
    logic [N_REQ-1:0] pick_oh;
    logic             wd_expire;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .id  (pick_id),
        .oh  (pick_oh)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = grant_valid;
        oh_d    = grant_oh;
        id_d    = grant_id;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    valid_d = 1'b1;
                    oh_d    = pick_oh;
                    id_d    = pick_id;
                end
            end
            ST_GRANT: begin
                // grant_id is kept so an idle arbiter still reports the last owner
                if (grant_release || wd_expire) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    oh_d    = '0;
                    ptr_d   = grant_id + ID_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_valid <= 1'b0;
            grant_oh    <= '0;
            grant_id    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_valid <= valid_d;
            grant_oh    <= oh_d;
            grant_id    <= id_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q;

    assign wd_expire = (state_q == ST_GRANT) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // An owner release on the expiry cycle wins, so no timeout is flagged then.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_q    <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= wd_expire && !grant_release;
            if (state_q == ST_GRANT && !grant_release && !wd_expire) begin
                wd_q <= wd_q + WD_W'(1);
            end else begin
                wd_q <= '0;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb/tb_rr_arbiter_16.sv - directed bench with a behavioural arbiter model for rr_arbiter_16
module tb_rr_arbiter_16;

`ifdef ARB_TIMEOUT_EN
    localparam int TO      = 8;
    localparam bit TO_EN   = 1'b1;
`else
    localparam int TO      = 256;
    localparam bit TO_EN   = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic [15:0] req;
    logic        grant_release;
    logic        grant_valid;
    logic [15:0] grant_oh;
    logic [3:0]  grant_id;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ARB_TIMEOUT_EN
    rr_arbiter_16 #(.TIMEOUT_CYCLES(TO)) dut (
`else
    rr_arbiter_16 dut (
`endif
        .clk           (clk),
        .resetn        (resetn),
        .req           (req),
        .grant_release (grant_release),
        .grant_valid   (grant_valid),
        .grant_oh      (grant_oh),
        .grant_id      (grant_id),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: owner index or idle, next-round start pointer, cycles held so far.
    bit m_valid;
    int m_id;
    int m_ptr;
    int m_hold;
    bit m_timeout;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid = 0; m_id = 0; m_ptr = 0; m_hold = 0; m_timeout = 0;
        end else begin
            m_timeout = 0;
            if (m_valid) begin
                if (grant_release) begin
                    m_valid = 0;
                    m_ptr   = (m_id + 1) % 16;
                end else if (TO_EN && m_hold == TO - 1) begin
                    m_valid   = 0;
                    m_ptr     = (m_id + 1) % 16;
                    m_timeout = 1;
                end else begin
                    m_hold++;
                end
            end else if (req != 16'h0) begin
                for (int k = 0; k < 16; k++) begin
                    if (!m_valid && req[(m_ptr + k) % 16]) begin
                        m_valid = 1;
                        m_id    = (m_ptr + k) % 16;
                    end
                end
                m_hold = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_valid", {31'd0, grant_valid}, {31'd0, m_valid});
        chk("cmp_oh", {16'd0, grant_oh}, m_valid ? (32'd1 << m_id) : 32'd0);
        chk("cmp_id", {28'd0, grant_id}, 32'(m_id));
        chk("cmp_timeout", {31'd0, timeout}, {31'd0, m_timeout});
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        resetn = 1'b0; req = '0; grant_release = 1'b0;
        cyc(2);
        chk("reset_valid", {31'd0, grant_valid}, 32'd0);
        chk("reset_oh", {16'd0, grant_oh}, 32'd0);
        chk("reset_id", {28'd0, grant_id}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        resetn = 1'b1;

        // single requester, one-cycle latency, release moves ptr to 1
        req = 16'h0001; cyc();
        chk("g0_valid", {31'd0, grant_valid}, 32'd1);
        chk("g0_id", {28'd0, grant_id}, 32'd0);
        chk("g0_oh", {16'd0, grant_oh}, 32'h0001);
        grant_release = 1'b1; req = '0; cyc(); grant_release = 1'b0;
        chk("rel0_valid", {31'd0, grant_valid}, 32'd0);
        chk("rel0_ptr", 32'(m_ptr), 32'd1);

        // release while idle is ignored
        grant_release = 1'b1; cyc(); grant_release = 1'b0;
        chk("idle_rel_ptr", 32'(m_ptr), 32'd1);

        // ptr=1 with bits 15 and 0: wrap order gives 15 then 0
        req = 16'h8001; cyc();
        chk("wrap_id15", {28'd0, grant_id}, 32'd15);
        grant_release = 1'b1; cyc(); grant_release = 1'b0;
        chk("wrap_ptr0", 32'(m_ptr), 32'd0);
        chk("wrap_idle", {31'd0, grant_valid}, 32'd0);
        cyc();
        chk("wrap_id0", {28'd0, grant_id}, 32'd0);
        grant_release = 1'b1; req = '0; cyc(); grant_release = 1'b0;

        // full request rotation from a fresh reset
        resetn = 1'b0; cyc(); resetn = 1'b1;
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            cyc();
            chk("rot_id", {28'd0, grant_id}, 32'(i % 16));
            chk("rot_valid", {31'd0, grant_valid}, 32'd1);
            if (i == 16) req = '0;
            grant_release = 1'b1; cyc(); grant_release = 1'b0;
            chk("rot_gap", {31'd0, grant_valid}, 32'd0);
        end

        // grant is frozen against request changes until release
        req = 16'h0008; cyc();
        chk("hold_id3", {28'd0, grant_id}, 32'd3);
        req = 16'h0080; cyc(3);
        chk("hold_still3", {28'd0, grant_id}, 32'd3);
        chk("hold_oh3", {16'd0, grant_oh}, 32'h0008);
        grant_release = 1'b1; cyc(); grant_release = 1'b0;
        cyc();
        chk("hold_id7", {28'd0, grant_id}, 32'd7);
        grant_release = 1'b1; req = '0; cyc(); grant_release = 1'b0;

        // asynchronous reset mid-grant
        req = 16'h0200; cyc();
        chk("ar_id9", {28'd0, grant_id}, 32'd9);
        #2 resetn = 1'b0;
        #1;
        chk("ar_valid", {31'd0, grant_valid}, 32'd0);
        chk("ar_oh", {16'd0, grant_oh}, 32'd0);
        chk("ar_id", {28'd0, grant_id}, 32'd0);
        cyc(); resetn = 1'b1;
        req = 16'h0101; cyc();
        chk("ar_first", {28'd0, grant_id}, 32'd0);
        grant_release = 1'b1; req = '0; cyc(); grant_release = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // ptr=1 here; watchdog revokes after cycle 8 of the grant
        req = 16'h0004; cyc();
        cyc(7);
        chk("to_pre_valid", {31'd0, grant_valid}, 32'd1);
        chk("to_pre_pulse", {31'd0, timeout}, 32'd0);
        cyc();
        chk("to_pulse", {31'd0, timeout}, 32'd1);
        chk("to_valid", {31'd0, grant_valid}, 32'd0);
        chk("to_ptr", 32'(m_ptr), 32'd3);
        cyc();
        chk("to_pulse_end", {31'd0, timeout}, 32'd0);
        chk("to_regrant", {28'd0, grant_id}, 32'd2);
        cyc(7);
        grant_release = 1'b1; cyc(); grant_release = 1'b0;
        chk("to_rel_wins", {31'd0, timeout}, 32'd0);
        chk("to_rel_valid", {31'd0, grant_valid}, 32'd0);
        req = '0; cyc();
`else
        // without the watchdog a grant is held indefinitely
        req = 16'h0004; cyc();
        cyc(300);
        chk("hold_long_valid", {31'd0, grant_valid}, 32'd1);
        chk("hold_long_id", {28'd0, grant_id}, 32'd2);
        chk("hold_long_to", {31'd0, timeout}, 32'd0);
        grant_release = 1'b1; req = '0; cyc(); grant_release = 1'b0;
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
